// File: rtl/l1_trigger_pkg.sv
// ----------------------------------------------------------------------------
// l1_trigger_pkg
//  Shared types for the L1 trigger event collector:
//   - collector_state_t : collector FSM states
//   - l1_event_t        : event word {timestamp, beam mask} at the default sizes
//   - DROP_CNT_BITS     : width of the saturating drop counter
//  No ports (package).
// ----------------------------------------------------------------------------
package l1_trigger_pkg;

   localparam int DEFAULT_NBEAMS  = 2;
   localparam int DEFAULT_TS_BITS = 32;
   localparam int DROP_CNT_BITS   = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      PUSH    = 2'd2,
      DEAD    = 2'd3
   } collector_state_t;

   typedef struct packed {
      logic [DEFAULT_TS_BITS-1:0] ts;
      logic [DEFAULT_NBEAMS-1:0]  mask;
   } l1_event_t;

endpackage

// File: rtl/l1_event_fifo.sv
// ----------------------------------------------------------------------------
// l1_event_fifo
//  Synchronous first-word-fall-through FIFO on distributed RAM. The head word
//  is visible on dout whenever the FIFO is non-empty; rd_en consumes it.
//  A write while full is accepted only when a read happens in the same cycle.
// Ports:
//  aclk, aresetn : clock, asynchronous active-low reset
//  wr_en, din    : write request and data
//  full          : count == DEPTH
//  rd_en, dout   : read (pop) request and head word (0 when empty)
//  empty, count  : status and occupancy
// ----------------------------------------------------------------------------
module l1_event_fifo #(
   parameter int WIDTH = 34,
   parameter int DEPTH = 16
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           din,
   output logic                       full,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           dout,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             doWrite, doRead;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign dout  = empty ? '0 : mem[rdPtr_q];

   // A read only happens on a non-empty FIFO; a write into a full FIFO is
   // allowed when the same cycle frees the head slot.
   always_comb begin
      doRead  = rd_en && !empty;
      doWrite = wr_en && (!full || doRead);
      wrPtr_d = doWrite ? wrPtr_q + PTR_W'(1) : wrPtr_q;
      rdPtr_d = doRead  ? rdPtr_q + PTR_W'(1) : rdPtr_q;
      count_d = count_q;
      if (doWrite && !doRead) begin
         count_d = count_q + CNT_W'(1);
      end else if (!doWrite && doRead) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Storage array is left unreset so it maps onto distributed RAM.
   always_ff @(posedge aclk) begin
      if (doWrite) begin
         mem[wrPtr_q] <= din;
      end
   end

endmodule

// File: rtl/l1_trigger_event_collector.sv
// ----------------------------------------------------------------------------
// l1_trigger_event_collector
//  Coalesces per-beam L1 trigger pulses within a short window into a single
//  event {timestamp, beam mask}, applies a dead time after each event and
//  queues events in a FWFT FIFO read out as a valid/ready stream. Events that
//  find the FIFO full are dropped and counted (saturating).
// Ports:
//  aclk, aresetn  : sole clock, asynchronous active-low reset
//  trig_i         : per-beam trigger pulses
//  enable_i       : allows new events to start from IDLE
//  m_tdata_o      : head event word {timestamp, beam_mask}
//  m_tvalid_o     : FIFO non-empty
//  m_tready_i     : consumer accepts head word
//  fifo_count_o   : FIFO occupancy
//  dropped_o      : saturating count of events dropped on a full FIFO
// ----------------------------------------------------------------------------
module l1_trigger_event_collector
   import l1_trigger_pkg::*;
#(
   parameter int NBEAMS          = DEFAULT_NBEAMS,
   parameter int WINDOW_CLOCKS   = 8,
   parameter int DEADTIME_CLOCKS = 16,
   parameter int TS_BITS         = DEFAULT_TS_BITS,
   parameter int FIFO_DEPTH      = 16
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic [NBEAMS-1:0]             trig_i,
   input  logic                          enable_i,
   output logic [TS_BITS+NBEAMS-1:0]     m_tdata_o,
   output logic                          m_tvalid_o,
   input  logic                          m_tready_i,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
   output logic [DROP_CNT_BITS-1:0]      dropped_o
);

   localparam int WORD_W  = TS_BITS + NBEAMS;
   localparam int MAX_CNT = (WINDOW_CLOCKS > DEADTIME_CLOCKS) ? WINDOW_CLOCKS : DEADTIME_CLOCKS;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);

   collector_state_t state_q, state_d;

   logic [TS_BITS-1:0]       ts_q, ts_d;
   logic [TS_BITS-1:0]       evTs_q, evTs_d;
   logic [NBEAMS-1:0]        mask_q, mask_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [DROP_CNT_BITS-1:0] dropped_q, dropped_d;

   logic              startEvent;
   logic              collecting;
   logic              pushCycle;
   logic              pop;
   logic              fifoFull;
   logic              fifoEmpty;
   logic              fifoWrEn;
   logic              dropEvent;
   logic [WORD_W-1:0] fifoDout;

   // State register.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. The shared counter holds the remaining window cycles in
   // COLLECT and the remaining dead cycles in DEAD; leaving happens when it
   // reaches its last cycle (value 1).
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (enable_i && |trig_i) begin
               state_d = (WINDOW_CLOCKS == 1) ? PUSH : COLLECT;
            end
         end
         COLLECT: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = PUSH;
            end
         end
         PUSH: begin
            state_d = (DEADTIME_CLOCKS == 0) ? IDLE : DEAD;
         end
         DEAD: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs. A PUSH into a full FIFO still succeeds if the consumer pops
   // the head in the same cycle; otherwise the event is dropped.
   always_comb begin
      startEvent = (state_q == IDLE) && enable_i && (|trig_i);
      collecting = (state_q == COLLECT);
      pushCycle  = (state_q == PUSH);
      fifoWrEn   = pushCycle && (!fifoFull || pop);
      dropEvent  = pushCycle && fifoFull && !pop;
   end

   assign pop = !fifoEmpty && m_tready_i;

   // Datapath next values: free-running timestamp, event latch, mask
   // accumulation, window/dead counter and the saturating drop counter.
   always_comb begin
      ts_d      = ts_q + TS_BITS'(1);
      evTs_d    = evTs_q;
      mask_d    = mask_q;
      cnt_d     = cnt_q;
      dropped_d = dropped_q;
      if (startEvent) begin
         evTs_d = ts_q;
         mask_d = trig_i;
         cnt_d  = CNT_W'(WINDOW_CLOCKS - 1);
      end else if (collecting) begin
         mask_d = mask_q | trig_i;
         cnt_d  = cnt_q - CNT_W'(1);
      end else if (pushCycle) begin
         cnt_d  = CNT_W'(DEADTIME_CLOCKS);
      end else if (state_q == DEAD) begin
         cnt_d  = cnt_q - CNT_W'(1);
      end
      if (dropEvent && (dropped_q != '1)) begin
         dropped_d = dropped_q + DROP_CNT_BITS'(1);
      end
   end

   // Datapath registers; reset discards any event being collected.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         ts_q      <= '0;
         evTs_q    <= '0;
         mask_q    <= '0;
         cnt_q     <= '0;
         dropped_q <= '0;
      end else begin
         ts_q      <= ts_d;
         evTs_q    <= evTs_d;
         mask_q    <= mask_d;
         cnt_q     <= cnt_d;
         dropped_q <= dropped_d;
      end
   end

   l1_event_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) uEventFifo (
      .aclk    (aclk),
      .aresetn (aresetn),
      .wr_en   (fifoWrEn),
      .din     ({evTs_q, mask_q}),
      .full    (fifoFull),
      .rd_en   (pop),
      .dout    (fifoDout),
      .empty   (fifoEmpty),
      .count   (fifo_count_o)
   );

   assign m_tdata_o  = fifoDout;
   assign m_tvalid_o = !fifoEmpty;
   assign dropped_o  = dropped_q;

endmodule

// File: tb/tb_l1_trigger_event_collector.sv
// ----------------------------------------------------------------------------
// tb_l1_trigger_event_collector
//  Self-checking bench for l1_trigger_event_collector (W=8, D=16, DEPTH=16).
//  Expected event words are queued when triggers are driven and compared by a
//  monitor whenever the stream hands over a word.
// ----------------------------------------------------------------------------
module tb_l1_trigger_event_collector;
   import l1_trigger_pkg::*;

   localparam int NBEAMS  = 2;
   localparam int TS_BITS = 32;
   localparam int WORD_W  = TS_BITS + NBEAMS;

   logic              aclk = 1'b0;
   logic              aresetn;
   logic [NBEAMS-1:0] trig_i;
   logic              enable_i;
   logic [WORD_W-1:0] m_tdata_o;
   logic              m_tvalid_o;
   logic              m_tready_i;
   logic [4:0]        fifo_count_o;
   logic [15:0]       dropped_o;

   int compared   = 0;
   int mismatched = 0;
   int tbTs;
   logic [WORD_W-1:0] expQ [$];

   l1_trigger_event_collector #(
      .NBEAMS          (NBEAMS),
      .WINDOW_CLOCKS   (8),
      .DEADTIME_CLOCKS (16),
      .TS_BITS         (TS_BITS),
      .FIFO_DEPTH      (16)
   ) dut (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .trig_i       (trig_i),
      .enable_i     (enable_i),
      .m_tdata_o    (m_tdata_o),
      .m_tvalid_o   (m_tvalid_o),
      .m_tready_i   (m_tready_i),
      .fifo_count_o (fifo_count_o),
      .dropped_o    (dropped_o)
   );

   // Free-running clock.
   always #5 aclk = ~aclk;

   // Reference timestamp: zero in reset, counts every clock afterwards.
   always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         tbTs <= 0;
      end else begin
         tbTs <= tbTs + 1;
      end
   end

   // Scoreboard monitor: every handshake must match the oldest expected word.
   always @(negedge aclk) begin
      if (aresetn === 1'b1 && m_tvalid_o === 1'b1 && m_tready_i === 1'b1) begin
         compared++;
         if (expQ.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL stream_word unexpected: actual %h, required none", m_tdata_o);
         end else begin
            logic [WORD_W-1:0] exp;
            exp = expQ.pop_front();
            if (m_tdata_o !== exp) begin
               mismatched++;
               $display("[TB] FAIL stream_word: actual %h, required %h", m_tdata_o, exp);
            end
         end
      end
   end

   function automatic logic [WORD_W-1:0] mkWord(input int t, input logic [NBEAMS-1:0] m);
      l1_event_t e;
      e.ts   = 32'(t);
      e.mask = m;
      return e;
   endfunction

   // Advance (at posedge+1) until the reference timestamp reaches t.
   task automatic goTo(input int t);
      int budget = 3000;
      while (tbTs != t && budget > 0) begin
         @(posedge aclk);
         #1;
         budget--;
      end
      if (tbTs != t) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL goTo timeout: actual ts %0d, required %0d", tbTs, t);
      end
   endtask

   task automatic pulse(input int t, input logic [NBEAMS-1:0] m);
      goTo(t);
      trig_i = m;
      goTo(t + 1);
      trig_i = '0;
   endtask

   task automatic checkVal(input string name, input longint actual, input longint required);
      compared++;
      if (actual != required) begin
         mismatched++;
         $display("[TB] FAIL %s: actual %0d, required %0d", name, actual, required);
      end
   endtask

   // Open the stream until every expected word has been consumed.
   task automatic drain(input string name);
      int budget = 200;
      m_tready_i = 1'b1;
      while (expQ.size() != 0 && budget > 0) begin
         @(posedge aclk);
         #1;
         budget--;
      end
      m_tready_i = 1'b0;
      checkVal({name, "_leftover"}, expQ.size(), 0);
      checkVal({name, "_count_after_drain"}, fifo_count_o, 0);
      checkVal({name, "_tvalid_after_drain"}, m_tvalid_o, 0);
   endtask

   task automatic test_reset();
      aresetn    = 1'b0;
      trig_i     = '0;
      enable_i   = 1'b1;
      m_tready_i = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      checkVal("reset_tvalid", m_tvalid_o, 0);
      checkVal("reset_tdata", (m_tdata_o == '0) ? 1 : 0, 1);
      checkVal("reset_count", fifo_count_o, 0);
      checkVal("reset_dropped", dropped_o, 0);
      aresetn = 1'b1;
   endtask

   task automatic test_coalesce();
      pulse(100, 2'b01);
      pulse(103, 2'b10);
      expQ.push_back(mkWord(100, 2'b11));
      goTo(108);
      checkVal("coalesce_tvalid_early", m_tvalid_o, 0);
      goTo(109);
      checkVal("coalesce_tvalid_at_109", m_tvalid_o, 1);
      checkVal("coalesce_count", fifo_count_o, 1);
      drain("coalesce");
   endtask

   task automatic test_deadtime();
      pulse(200, 2'b01);
      expQ.push_back(mkWord(200, 2'b01));
      pulse(210, 2'b01);
      goTo(224);
      trig_i = 2'b01;
      goTo(226);
      trig_i = '0;
      expQ.push_back(mkWord(225, 2'b01));
      goTo(240);
      checkVal("deadtime_count", fifo_count_o, 2);
      drain("deadtime");
   endtask

   task automatic test_overflow();
      for (int k = 0; k < 20; k++) begin
         pulse(300 + 30 * k, (k % 2 == 1) ? 2'b10 : 2'b01);
         if (k < 16) expQ.push_back(mkWord(300 + 30 * k, (k % 2 == 1) ? 2'b10 : 2'b01));
      end
      goTo(900);
      checkVal("overflow_count", fifo_count_o, 16);
      checkVal("overflow_dropped", dropped_o, 4);
      checkVal("overflow_tvalid", m_tvalid_o, 1);
      drain("overflow");
   endtask

   task automatic test_full_pop_at_push();
      for (int k = 0; k < 16; k++) begin
         pulse(1000 + 30 * k, 2'b10);
         expQ.push_back(mkWord(1000 + 30 * k, 2'b10));
      end
      pulse(1480, 2'b01);
      expQ.push_back(mkWord(1480, 2'b01));
      goTo(1487);
      checkVal("fullpop_count_before", fifo_count_o, 16);
      goTo(1488);
      m_tready_i = 1'b1;
      goTo(1489);
      m_tready_i = 1'b0;
      checkVal("fullpop_count_after", fifo_count_o, 16);
      checkVal("fullpop_dropped", dropped_o, 4);
      drain("fullpop");
   endtask

   task automatic test_enable();
      enable_i = 1'b0;
      pulse(1700, 2'b01);
      pulse(1705, 2'b11);
      goTo(1730);
      checkVal("enable_off_count", fifo_count_o, 0);
      checkVal("enable_off_tvalid", m_tvalid_o, 0);
      enable_i = 1'b1;
      pulse(1740, 2'b01);
      goTo(1742);
      enable_i = 1'b0;
      pulse(1744, 2'b10);
      expQ.push_back(mkWord(1740, 2'b11));
      goTo(1749);
      checkVal("enable_drop_tvalid", m_tvalid_o, 1);
      enable_i = 1'b1;
      drain("enable");
   endtask

   task automatic test_reset_mid_event();
      pulse(1800, 2'b01);
      pulse(1830, 2'b10);
      pulse(1860, 2'b11);
      pulse(1890, 2'b01);
      goTo(1893);
      checkVal("midreset_count_before", fifo_count_o, 3);
      aresetn = 1'b0;
      #1;
      checkVal("midreset_tvalid", m_tvalid_o, 0);
      checkVal("midreset_count", fifo_count_o, 0);
      checkVal("midreset_tdata", (m_tdata_o == '0) ? 1 : 0, 1);
      checkVal("midreset_dropped", dropped_o, 0);
      expQ.delete();
      repeat (2) @(posedge aclk);
      #1;
      aresetn = 1'b1;
      goTo(12);
      checkVal("midreset_no_partial_push", fifo_count_o, 0);
      pulse(20, 2'b01);
      expQ.push_back(mkWord(20, 2'b01));
      goTo(29);
      checkVal("midreset_new_event_tvalid", m_tvalid_o, 1);
      drain("midreset");
   endtask

   initial begin
      test_reset();
      test_coalesce();
      test_deadtime();
      test_overflow();
      test_full_pop_at_push();
      test_enable();
      test_reset_mid_event();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
